axil_uartlite_master: RTL

// - Parametrised AXI4-Lite master for the UART Lite core; replaces single-shot read/write sequencing.
// - Buffers TX bytes and RX bytes in local FIFOs, polls STAT_REG autonomously, honours TX-full.
// - Checks RRESP/BRESP and recovers from hung handshakes via timeout.
// - Sits between user logic (valid/ready byte streams) and the UART Lite AXI slave port.

---
 rtl/axil_uartlite_master_pkg.sv | 27 ++
 rtl/axil_uartlite_master_sync_fifo.sv | 45 ++++
 rtl/axil_uartlite_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_uartlite_master_pkg.sv
// Shared register map, status bit positions, error flag positions and FSM states
// for the AXI4-Lite master that drives the UART Lite core.
package axil_uartlite_master_pkg;

  localparam logic [7:0] RX_FIFO_ADDR  = 8'h00;
  localparam logic [7:0] TX_FIFO_ADDR  = 8'h04;
  localparam logic [7:0] STAT_REG_ADDR = 8'h08;

  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_TX_FULL  = 3;

  localparam int unsigned ERR_RRESP   = 0;
  localparam int unsigned ERR_BRESP   = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_STAT    = 3;

  typedef enum logic [2:0] {
    IDLE,
    ST_AR,
    ST_R,
    RX_AR,
    RX_R,
    TX_AW,
    TX_B
  } state_e;

endpackage

// File: rtl/axil_uartlite_master_sync_fifo.sv
// Synchronous FIFO; full/empty from an extra pointer bit, read head is combinational.
module axil_uartlite_master_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_c    = mem[rd_ptr[AW-1:0]];
  // A pop frees the slot a same-cycle push into a full FIFO needs; popping empty is a no-op.
  assign do_pop_c  = pop && !empty_c;
  assign do_push_c = push && (!full_c || do_pop_c);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push_c) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axil_uartlite_master.sv
// AXI4-Lite master for UART Lite: buffers TX/RX bytes locally, polls STAT_REG,
// moves one byte per AXI round and aborts any handshake that hangs.
module axil_uartlite_master
  import axil_uartlite_master_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned TXQ_DEPTH = 8,
  parameter int unsigned RXQ_DEPTH = 8,
  parameter int unsigned POLL_IVL  = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [7:0]        o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic [7:0]        o_stat,
  output logic [3:0]        o_err,
  input  logic              i_err_clr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [31:0]       i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [31:0]       o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready
);

  localparam int unsigned PW = $clog2(POLL_IVL) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  state_e        state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] to_cnt;

  logic [7:0] tx_head_c;
  logic       tx_full_c;
  logic       tx_empty_c;
  logic       tx_pop_c;
  logic       rx_full_c;
  logic       rx_empty_c;
  logic       rx_push_c;
  logic       aw_done_c;
  logic       w_done_c;
  logic       hs_c;
  logic       timeout_c;
  logic [3:0] err_set_c;
  logic       unused_c;

  axil_uartlite_master_sync_fifo #(.WIDTH(8), .DEPTH(TXQ_DEPTH)) u_txq (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (i_tx_valid && !tx_full_c),
    .push_data (i_tx_data),
    .pop       (tx_pop_c),
    .head_c    (tx_head_c),
    .full_c    (tx_full_c),
    .empty_c   (tx_empty_c)
  );

  axil_uartlite_master_sync_fifo #(.WIDTH(8), .DEPTH(RXQ_DEPTH)) u_rxq (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (rx_push_c),
    .push_data (i_rdata[7:0]),
    .pop       (i_rx_ready),
    .head_c    (o_rx_data),
    .full_c    (rx_full_c),
    .empty_c   (rx_empty_c)
  );

  assign o_tx_ready = !tx_full_c;
  assign o_rx_valid = !rx_empty_c;
  assign o_busy     = (state != IDLE);
  assign unused_c   = ^{i_rdata[31:8], i_rresp[0], i_bresp[0]};

  assign tx_pop_c  = (state == TX_B) && i_bvalid;
  assign rx_push_c = (state == RX_R) && i_rvalid;
  assign aw_done_c = !o_awvalid || i_awready;
  assign w_done_c  = !o_wvalid || i_wready;
  assign timeout_c = (to_cnt == TW'(TIMEOUT - 1));

  // Handshake that completes the current state; it takes priority over a same-cycle timeout.
  always_comb begin
    hs_c = 1'b0;
    case (state)
      ST_AR, RX_AR: hs_c = i_arready;
      ST_R, RX_R:   hs_c = i_rvalid;
      TX_AW:        hs_c = aw_done_c && w_done_c;
      TX_B:         hs_c = i_bvalid;
      default:      hs_c = 1'b0;
    endcase
  end

  always_comb begin
    err_set_c = '0;
    if ((state == ST_R || state == RX_R) && i_rvalid && i_rresp[1]) err_set_c[ERR_RRESP] = 1'b1;
    if (state == TX_B && i_bvalid && i_bresp[1])                    err_set_c[ERR_BRESP] = 1'b1;
    if (state == ST_R && i_rvalid && (i_rdata[7:5] != 3'b000))      err_set_c[ERR_STAT]  = 1'b1;
    if (state != IDLE && timeout_c && !hs_c)                        err_set_c[ERR_TIMEOUT] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      poll_cnt  <= '0;
      to_cnt    <= '0;
      o_stat    <= '0;
      o_err     <= '0;
      o_araddr  <= '0;
      o_arvalid <= 1'b0;
      o_rready  <= 1'b0;
      o_awaddr  <= '0;
      o_awvalid <= 1'b0;
      o_wdata   <= '0;
      o_wstrb   <= '0;
      o_wvalid  <= 1'b0;
      o_bready  <= 1'b0;
    end else begin
      o_err  <= (o_err & ~{4{i_err_clr}}) | err_set_c;
      to_cnt <= (state == IDLE || hs_c) ? '0 : to_cnt + TW'(1);

      case (state)
        IDLE: begin
          if (!tx_empty_c || poll_cnt == PW'(POLL_IVL - 1)) begin
            poll_cnt  <= '0;
            state     <= ST_AR;
            o_araddr  <= ADDR_W'(STAT_REG_ADDR);
            o_arvalid <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        ST_AR, RX_AR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= (state == ST_AR) ? ST_R : RX_R;
          end
        end
        ST_R: begin
          if (i_rvalid) begin
            o_rready <= 1'b0;
            o_stat   <= i_rdata[7:0];
            if (i_rdata[STAT_RX_VALID] && !rx_full_c) begin
              state     <= RX_AR;
              o_araddr  <= ADDR_W'(RX_FIFO_ADDR);
              o_arvalid <= 1'b1;
            end else if (!tx_empty_c && !i_rdata[STAT_TX_FULL]) begin
              state     <= TX_AW;
              o_awaddr  <= ADDR_W'(TX_FIFO_ADDR);
              o_awvalid <= 1'b1;
              o_wdata   <= {24'd0, tx_head_c};
              o_wstrb   <= 4'h1;
              o_wvalid  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        RX_R: begin
          if (i_rvalid) begin
            o_rready <= 1'b0;
            state    <= IDLE;
          end
        end
        TX_AW: begin
          if (o_awvalid && i_awready) o_awvalid <= 1'b0;
          if (o_wvalid && i_wready)   o_wvalid  <= 1'b0;
          if (hs_c) begin
            state    <= TX_B;
            o_bready <= 1'b1;
          end
        end
        TX_B: begin
          if (i_bvalid) begin
            o_bready <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Hung handshake: abandon the transaction; an unpopped TX head is retried later.
      if (state != IDLE && timeout_c && !hs_c) begin
        state     <= IDLE;
        o_arvalid <= 1'b0;
        o_rready  <= 1'b0;
        o_awvalid <= 1'b0;
        o_wvalid  <= 1'b0;
        o_bready  <= 1'b0;
      end
    end
  end

endmodule
